rs_multi_cdb: RTL and testbench
===============================

Name: rs_multi_cdb

Overview:
- Parametrised reservation station: successor to the single-issue ALU RS.
- Buffers DEPTH decoded ALU ops between decoder/rename and the ALU.
- Snoops NUM_CDB result broadcast channels (ALU, LSB, ...) to wake up waiting operands.
- Issues at most one ready op per cycle, oldest-first, over a valid/ready handshake; supports full flush on branch mispredict.

Parameters:
DEPTH, 16, number of entries (power of 2, >=2)
XLEN, 32, operand/immediate width
OP_W, 6, opcode id width
ROB_W, 4, ROB tag width
NUM_CDB, 2, number of broadcast channels (channel 0 highest priority)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
rdy  in  1  global enable; 0 freezes all state
flush  in  1  synchronous clear of all entries (mispredict)
in_valid  in  1  dispatch request
in_opcode  in  OP_W  opcode id
in_use_imm  in  1  1: operand k is the immediate, vk ignored and treated ready
in_qj_ready  in  1  1: in_vj holds a value; 0: in_vj[ROB_W-1:0] is a ROB tag
in_qk_ready  in  1  same for k
in_vj  in  XLEN  value or tag
in_vk  in  XLEN  value or tag
in_imm  in  XLEN  immediate
in_rob  in  ROB_W  destination ROB tag
rs_full  out  1  all entries busy
rs_count  out  $clog2(DEPTH)+1  busy entry count
cdb_valid  in  NUM_CDB  per-channel broadcast valid
cdb_tag  in  NUM_CDB*ROB_W  packed tags, channel c at [c*ROB_W +: ROB_W]
cdb_val  in  NUM_CDB*XLEN  packed values
ex_valid  out  1  an issuable op is presented
ex_ready  in  1  ALU accepts
ex_opcode  out  OP_W
ex_vj  out  XLEN
ex_vk  out  XLEN
ex_imm  out  XLEN
ex_rob  out  ROB_W

Behaviour:
- Reset (rst=0, async): all entries not busy; rs_full=0, rs_count=0, ex_valid=0, all ex_* fields 0. On release, first accept is possible at the next edge.
- Dispatch: accepted at an edge when rdy && in_valid && !rs_full && !flush. It is written into the lowest-index free entry. rs_full is computed from registered state only; a same-cycle issue does not open a slot. If in_valid is asserted while rs_full, the request is ignored and the decoder must hold it.
- Dispatch bypass: if an incoming operand is not ready and a valid CDB channel tag equals its tag in the same cycle, the entry captures cdb_val and is written ready. If several channels match, the lowest channel index wins.
- in_use_imm=1: the entry stores vk=0 and qk ready; ex_imm=in_imm. Otherwise ex_imm=0.
- Wakeup: at each rdy edge, every busy entry with a not-ready operand whose tag matches a valid channel captures that value (lowest channel wins) and becomes ready.
- Issue select: combinational over registered state. An entry is a candidate when busy and both operands are ready. The oldest candidate by dispatch order is selected, using an age matrix or equivalent.
  - Entries woken this cycle become candidates next cycle (1-cycle wakeup-to-issue minimum).
  - Dispatch-to-issue is at least 1 cycle.
- ex_valid = rdy && !flush && (candidate exists). When ex_valid=0, all ex_* fields are 0. Fields are stable while ex_valid && !ex_ready.
- Handshake: transfer at an edge with ex_valid && ex_ready; the entry is freed at that edge. The same edge may also accept a dispatch into a different, already-free entry.
- rs_count: +1 on accept, -1 on transfer; both on the same edge leaves it unchanged.
- flush=1 at a rdy edge: all entries freed, rs_count=0, dispatch ignored, no transfer.
- rdy=0: no state change; ex_valid=0; CDB broadcasts in that cycle are lost (the producer must hold them).
- Reset mid-operation: all entries are discarded immediately; outputs go to their reset values.

Test Plan:
- Reset then dispatch ADD (vj=5 ready, vk=7 ready, rob=3) -> next cycle ex_valid=1, ex_vj=5, ex_vk=7, ex_rob=3; with ex_ready=1, ex_valid=0 the following cycle and rs_count returns to 0.
- Dispatch op A (qj tag 2, rob=4), then op B (ready, rob=5) -> B issues first. Broadcast cdb ch1 tag 2 val 0x11 -> A issues the cycle after, with ex_vj=0x11.
- Fill DEPTH=16 entries with unready ops -> rs_full=1, rs_count=16, and a 17th in_valid is ignored. A single wakeup plus transfer -> rs_full=0 the next cycle.
- Dispatch tag-6 operand in the same cycle as cdb ch0 tag 6 val 0xAB and ch1 tag 6 val 0xCD -> entry captures 0xAB and issues the next cycle.
- Two ready ops in the RS, ex_ready=0 for 3 cycles -> ex_* fields stay held on the older op; no loss, order preserved.
- 5 entries busy, assert flush together with in_valid -> rs_count=0 and ex_valid=0 next cycle; the dispatched op is not stored. Also assert rst=0 mid-issue -> ex_valid drops immediately.

Source files
------------

// File: rtl/rs_multi_cdb.sv
// Reservation station for ALU ops: DEPTH entries, NUM_CDB wakeup channels,
// oldest-first single issue over a valid/ready handshake, full flush support.
module rs_multi_cdb #(
   parameter int DEPTH   = 16,
   parameter int XLEN    = 32,
   parameter int OP_W    = 6,
   parameter int ROB_W   = 4,
   parameter int NUM_CDB = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       rdy,
   input  logic                       flush,
   input  logic                       in_valid,
   input  logic [OP_W-1:0]            in_opcode,
   input  logic                       in_use_imm,
   input  logic                       in_qj_ready,
   input  logic                       in_qk_ready,
   input  logic [XLEN-1:0]            in_vj,
   input  logic [XLEN-1:0]            in_vk,
   input  logic [XLEN-1:0]            in_imm,
   input  logic [ROB_W-1:0]           in_rob,
   output logic                       rs_full,
   output logic [$clog2(DEPTH):0]     rs_count,
   input  logic [NUM_CDB-1:0]         cdb_valid,
   input  logic [NUM_CDB*ROB_W-1:0]   cdb_tag,
   input  logic [NUM_CDB*XLEN-1:0]    cdb_val,
   output logic                       ex_valid,
   input  logic                       ex_ready,
   output logic [OP_W-1:0]            ex_opcode,
   output logic [XLEN-1:0]            ex_vj,
   output logic [XLEN-1:0]            ex_vk,
   output logic [XLEN-1:0]            ex_imm,
   output logic [ROB_W-1:0]           ex_rob
);
   localparam int IW = $clog2(DEPTH);

   logic [DEPTH-1:0] r_busy, r_rj, r_rk;
   logic [DEPTH-1:0] r_older [DEPTH];
   logic [OP_W-1:0]  r_op    [DEPTH];
   logic [XLEN-1:0]  r_vj    [DEPTH];
   logic [XLEN-1:0]  r_vk    [DEPTH];
   logic [XLEN-1:0]  r_imm   [DEPTH];
   logic [ROB_W-1:0] r_rob   [DEPTH];
   logic [IW:0]      r_count;
   logic             r_lock;
   logic [IW-1:0]    r_lock_idx;

   logic [XLEN:0]    w_snj [DEPTH];
   logic [XLEN:0]    w_snk [DEPTH];
   logic [XLEN:0]    w_dj, w_dk;
   logic             w_d_rj, w_d_rk;
   logic [XLEN-1:0]  w_d_vj, w_d_vk, w_d_imm;
   logic [DEPTH-1:0] w_cand, w_blk;
   logic             w_any, w_acc, w_xfer;
   logic [IW-1:0]    w_free, w_old_idx, w_sel_idx;

   // Returns {hit, value}; scanning high to low lets channel 0 win ties.
   function automatic logic [XLEN:0] cdb_snoop(input logic [ROB_W-1:0] tag,
                                                input logic [NUM_CDB-1:0] v,
                                                input logic [NUM_CDB*ROB_W-1:0] tags,
                                                input logic [NUM_CDB*XLEN-1:0] vals);
      logic [XLEN:0] res;
      res = '0;
      for (int c = NUM_CDB-1; c >= 0; c--)
         if (v[c] && tags[c*ROB_W +: ROB_W] == tag)
            res = {1'b1, vals[c*XLEN +: XLEN]};
      return res;
   endfunction

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_snj[i] = cdb_snoop(r_vj[i][ROB_W-1:0], cdb_valid, cdb_tag, cdb_val);
         w_snk[i] = cdb_snoop(r_vk[i][ROB_W-1:0], cdb_valid, cdb_tag, cdb_val);
      end
      w_dj = cdb_snoop(in_vj[ROB_W-1:0], cdb_valid, cdb_tag, cdb_val);
      w_dk = cdb_snoop(in_vk[ROB_W-1:0], cdb_valid, cdb_tag, cdb_val);
      w_d_rj = in_qj_ready | w_dj[XLEN];
      w_d_vj = (!in_qj_ready && w_dj[XLEN]) ? w_dj[XLEN-1:0] : in_vj;
      if (in_use_imm) begin
         w_d_rk = 1'b1;
         w_d_vk = '0;
      end else begin
         w_d_rk = in_qk_ready | w_dk[XLEN];
         w_d_vk = (!in_qk_ready && w_dk[XLEN]) ? w_dk[XLEN-1:0] : in_vk;
      end
      w_d_imm = in_use_imm ? in_imm : '0;
   end

   // Oldest candidate: one that no other candidate predates in the age matrix.
   always_comb begin
      w_cand    = r_busy & r_rj & r_rk;
      w_any     = |w_cand;
      w_blk     = '0;
      w_old_idx = '0;
      w_free    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         for (int j = 0; j < DEPTH; j++)
            if (w_cand[j] && r_older[j][i]) w_blk[i] = 1'b1;
         if (w_cand[i] && !w_blk[i]) w_old_idx = IW'(i);
      end
      for (int i = DEPTH-1; i >= 0; i--)
         if (!r_busy[i]) w_free = IW'(i);
      w_sel_idx = r_lock ? r_lock_idx : w_old_idx;
   end

   assign rs_full  = &r_busy;
   assign rs_count = r_count;
   assign w_acc    = rdy && in_valid && !rs_full && !flush;
   assign w_xfer   = ex_valid && ex_ready;

   always_comb begin
      ex_valid  = rdy && !flush && w_any;
      ex_opcode = '0;
      ex_vj     = '0;
      ex_vk     = '0;
      ex_imm    = '0;
      ex_rob    = '0;
      if (ex_valid) begin
         ex_opcode = r_op[w_sel_idx];
         ex_vj     = r_vj[w_sel_idx];
         ex_vk     = r_vk[w_sel_idx];
         ex_imm    = r_imm[w_sel_idx];
         ex_rob    = r_rob[w_sel_idx];
      end
   end

   // A stalled issue locks its entry so a late-woken older op cannot swap in.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_busy     <= '0;
         r_rj       <= '0;
         r_rk       <= '0;
         r_count    <= '0;
         r_lock     <= 1'b0;
         r_lock_idx <= '0;
         for (int i = 0; i < DEPTH; i++) r_older[i] <= '0;
      end else if (rdy) begin
         if (flush) begin
            r_busy  <= '0;
            r_count <= '0;
            r_lock  <= 1'b0;
         end else begin
            for (int i = 0; i < DEPTH; i++) begin
               if (r_busy[i] && !r_rj[i] && w_snj[i][XLEN]) r_rj[i] <= 1'b1;
               if (r_busy[i] && !r_rk[i] && w_snk[i][XLEN]) r_rk[i] <= 1'b1;
            end
            if (w_xfer) begin
               r_busy[w_sel_idx] <= 1'b0;
               r_lock            <= 1'b0;
            end else if (ex_valid) begin
               r_lock     <= 1'b1;
               r_lock_idx <= w_sel_idx;
            end
            if (w_acc) begin
               r_busy[w_free] <= 1'b1;
               r_rj[w_free]   <= w_d_rj;
               r_rk[w_free]   <= w_d_rk;
               r_older[w_free] <= '0;
               for (int j = 0; j < DEPTH; j++)
                  if (j != int'(w_free)) r_older[j][w_free] <= 1'b1;
            end
            r_count <= r_count + {{IW{1'b0}}, w_acc} - {{IW{1'b0}}, w_xfer};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rdy && !flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (r_busy[i] && !r_rj[i] && w_snj[i][XLEN]) r_vj[i] <= w_snj[i][XLEN-1:0];
            if (r_busy[i] && !r_rk[i] && w_snk[i][XLEN]) r_vk[i] <= w_snk[i][XLEN-1:0];
         end
         if (w_acc) begin
            r_op[w_free]  <= in_opcode;
            r_vj[w_free]  <= w_d_vj;
            r_vk[w_free]  <= w_d_vk;
            r_imm[w_free] <= w_d_imm;
            r_rob[w_free] <= in_rob;
         end
      end
   end
endmodule

// File: tb/tb_rs_multi_cdb.sv
// Bench for rs_multi_cdb: table of single-op vectors plus hand sequences,
// issued ops checked against an in-order scoreboard queue.
module tb_rs_multi_cdb;
   logic        clk = 1'b0;
   logic        rst, rdy, flush, in_valid, in_use_imm, in_qj_ready, in_qk_ready;
   logic [5:0]  in_opcode;
   logic [31:0] in_vj, in_vk, in_imm;
   logic [3:0]  in_rob;
   logic        rs_full;
   logic [4:0]  rs_count;
   logic [1:0]  cdb_valid;
   logic [7:0]  cdb_tag;
   logic [63:0] cdb_val;
   logic        ex_valid, ex_ready;
   logic [5:0]  ex_opcode;
   logic [31:0] ex_vj, ex_vk, ex_imm;
   logic [3:0]  ex_rob;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [5:0]  op;
      logic [31:0] vj, vk, imm;
      logic [3:0]  rob;
   } issue_t;

   typedef struct {
      logic [5:0]  op;
      logic [31:0] vj, vk;
      logic        rk, ui;
      logic [31:0] imm;
      logic [3:0]  rob;
      logic [31:0] e_vk, e_imm;
   } vec_t;

   issue_t sb[$];
   vec_t   tbl[5];

   rs_multi_cdb dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .in_valid(in_valid),
      .in_opcode(in_opcode), .in_use_imm(in_use_imm), .in_qj_ready(in_qj_ready),
      .in_qk_ready(in_qk_ready), .in_vj(in_vj), .in_vk(in_vk), .in_imm(in_imm),
      .in_rob(in_rob), .rs_full(rs_full), .rs_count(rs_count),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode),
      .ex_vj(ex_vj), .ex_vk(ex_vk), .ex_imm(ex_imm), .ex_rob(ex_rob)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic disp(input logic [5:0] op, input logic rj, input logic [31:0] vj,
                       input logic rk, input logic [31:0] vk, input logic ui,
                       input logic [31:0] imm, input logic [3:0] rob);
      in_valid = 1'b1; in_opcode = op; in_qj_ready = rj; in_vj = vj;
      in_qk_ready = rk; in_vk = vk; in_use_imm = ui; in_imm = imm; in_rob = rob;
   endtask

   // Scoreboard: every transfer must match the next expected op.
   always @(negedge clk) begin
      if (ex_valid === 1'b1 && ex_ready === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_extra: got rob %0h expected no issue", ex_rob);
         end else begin
            issue_t e;
            e = sb.pop_front();
            chk("sb_issue", {ex_opcode, ex_vj, ex_vk, ex_imm, ex_rob}, e);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{6'd1,  32'd5,          32'd7,          1'b1, 1'b0, 32'h0,        4'd3,  32'd7,          32'h0};
      tbl[1] = '{6'd2,  32'hFFFF_FFFF,  32'd1,          1'b1, 1'b0, 32'h1234,     4'd0,  32'd1,          32'h0};
      tbl[2] = '{6'd3,  32'h10,         32'hDEAD,       1'b1, 1'b1, 32'h40,       4'd15, 32'h0,          32'h40};
      tbl[3] = '{6'd63, 32'h8000_0000,  32'h7FFF_FFFF,  1'b1, 1'b0, 32'h0,        4'd9,  32'h7FFF_FFFF,  32'h0};
      tbl[4] = '{6'd4,  32'h0,          32'h999,        1'b0, 1'b1, 32'hFFFF_F000,4'd7,  32'h0,          32'hFFFF_F000};

      rst = 1'b0; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0; in_use_imm = 1'b0;
      in_qj_ready = 1'b0; in_qk_ready = 1'b0; in_opcode = '0; in_vj = '0; in_vk = '0;
      in_imm = '0; in_rob = '0; cdb_valid = '0; cdb_tag = '0; cdb_val = '0; ex_ready = 1'b0;
      tick(); tick();
      chk("rst_full", rs_full, 0);
      chk("rst_count", rs_count, 0);
      chk("rst_exv", ex_valid, 0);
      chk("rst_fields", {ex_opcode, ex_vj, ex_vk, ex_imm, ex_rob}, 0);
      rst = 1'b1;

      // Single ready ops, one at a time
      ex_ready = 1'b1;
      for (int n = 0; n < 5; n++) begin
         disp(tbl[n].op, 1'b1, tbl[n].vj, tbl[n].rk, tbl[n].vk, tbl[n].ui, tbl[n].imm, tbl[n].rob);
         sb.push_back('{tbl[n].op, tbl[n].vj, tbl[n].e_vk, tbl[n].e_imm, tbl[n].rob});
         tick();
         in_valid = 1'b0;
         #1 chk("tbl_exv", ex_valid, 1);
         chk("tbl_cnt1", rs_count, 1);
         tick();
         #1 chk("tbl_cnt0", rs_count, 0);
         chk("tbl_idle", ex_valid, 0);
      end

      // Younger ready op bypasses an older waiting one; CDB ch1 wakes the older
      disp(6'd2, 1'b0, 32'd2, 1'b1, 32'd3, 1'b0, 32'h0, 4'd4);
      tick();
      disp(6'd3, 1'b1, 32'h20, 1'b1, 32'h21, 1'b0, 32'h0, 4'd5);
      sb.push_back('{6'd3, 32'h20, 32'h21, 32'h0, 4'd5});
      #1 chk("ab_wait", ex_valid, 0);
      tick();
      in_valid = 1'b0;
      cdb_valid = 2'b10; cdb_tag = {4'd2, 4'd0}; cdb_val = {32'h11, 32'h0};
      sb.push_back('{6'd2, 32'h11, 32'd3, 32'h0, 4'd4});
      #1 chk("ab_b_first", ex_rob, 5);
      tick();
      cdb_valid = 2'b00;
      #1 chk("ab_a_vld", ex_valid, 1);
      chk("ab_a_vj", ex_vj, 32'h11);
      tick();
      #1 chk("ab_cnt", rs_count, 0);

      // Fill every entry with waiting ops, tag = entry number
      for (int i = 0; i < 16; i++) begin
         disp(6'(i), 1'b0, 32'(i), 1'b1, 32'(100 + i), 1'b0, 32'h0, 4'(i));
         tick();
      end
      in_valid = 1'b0;
      #1 chk("fill_full", rs_full, 1);
      chk("fill_cnt", rs_count, 16);
      chk("fill_exv", ex_valid, 0);
      disp(6'd50, 1'b1, 32'h5, 1'b1, 32'h6, 1'b0, 32'h0, 4'd15);
      tick();
      in_valid = 1'b0;
      #1 chk("full_ign_cnt", rs_count, 16);
      chk("full_ign_exv", ex_valid, 0);
      cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd7}; cdb_val = {32'h0, 32'h77};
      sb.push_back('{6'd7, 32'h77, 32'd107, 32'h0, 4'd7});
      tick();
      cdb_valid = 2'b00;
      #1 chk("wake_exv", ex_valid, 1);
      chk("wake_full", rs_full, 1);
      tick();
      #1 chk("unfull", rs_full, 0);
      chk("unfull_cnt", rs_count, 15);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1 chk("clr_cnt", rs_count, 0);

      // Dispatch bypass with both channels matching; ch0 must win
      disp(6'd9, 1'b0, 32'd6, 1'b1, 32'h55, 1'b0, 32'h0, 4'd6);
      cdb_valid = 2'b11; cdb_tag = {4'd6, 4'd6}; cdb_val = {32'hCD, 32'hAB};
      sb.push_back('{6'd9, 32'hAB, 32'h55, 32'h0, 4'd6});
      tick();
      in_valid = 1'b0; cdb_valid = 2'b00;
      #1 chk("byp_exv", ex_valid, 1);
      chk("byp_vj", ex_vj, 32'hAB);
      tick();
      #1 chk("byp_cnt", rs_count, 0);

      // Back-pressure: fields held on the older op, then order preserved
      ex_ready = 1'b0;
      disp(6'd10, 1'b1, 32'h100, 1'b1, 32'h101, 1'b0, 32'h0, 4'd1);
      sb.push_back('{6'd10, 32'h100, 32'h101, 32'h0, 4'd1});
      tick();
      disp(6'd11, 1'b1, 32'h200, 1'b1, 32'h201, 1'b0, 32'h0, 4'd2);
      sb.push_back('{6'd11, 32'h200, 32'h201, 32'h0, 4'd2});
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1 chk("hold_vld", ex_valid, 1);
         chk("hold_fields", {ex_rob, ex_vj}, {4'd1, 32'h100});
         tick();
      end
      rdy = 1'b0;
      #1 chk("rdy_low", ex_valid, 0);
      tick();
      rdy = 1'b1;
      #1 chk("rdy_back", ex_rob, 1);
      chk("rdy_cnt", rs_count, 2);
      ex_ready = 1'b1;
      tick();
      #1 chk("hold_second", ex_rob, 2);
      tick();
      #1 chk("hold_cnt", rs_count, 0);

      // Flush with five busy entries and a simultaneous dispatch
      ex_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         disp(6'(20 + i), 1'b0, 32'd10, 1'b1, 32'h0, 1'b0, 32'h0, 4'(8 + i));
         tick();
      end
      disp(6'd30, 1'b1, 32'h1, 1'b1, 32'h2, 1'b0, 32'h0, 4'd12);
      tick();
      in_valid = 1'b0;
      #1 chk("pre_fl_cnt", rs_count, 5);
      chk("pre_fl_exv", ex_valid, 1);
      flush = 1'b1;
      disp(6'd31, 1'b1, 32'h3, 1'b1, 32'h4, 1'b0, 32'h0, 4'd13);
      #1 chk("fl_exv", ex_valid, 0);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      #1 chk("fl_cnt", rs_count, 0);
      chk("fl_exv_after", ex_valid, 0);
      tick();
      #1 chk("fl_nostore", ex_valid, 0);

      // Asynchronous reset while an op is presented
      disp(6'd40, 1'b1, 32'h44, 1'b1, 32'h45, 1'b0, 32'h0, 4'd14);
      tick();
      in_valid = 1'b0;
      #1 chk("mid_exv", ex_valid, 1);
      rst = 1'b0;
      #1 chk("mid_rst_exv", ex_valid, 0);
      chk("mid_rst_vj", ex_vj, 0);
      chk("mid_rst_cnt", rs_count, 0);
      tick();
      rst = 1'b1;
      ex_ready = 1'b1;
      tick();
      #1 chk("post_rst_idle", ex_valid, 0);
      chk("sb_left", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
